// File: rtl/seq_mux_pkg.sv
// Shared definitions for seq_chan_mux.
//   MODE_DIRECT / MODE_SCAN : encodings of the mode input.
//   mode_e                  : state type of the mode FSM.
package seq_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ModeDirect = MODE_DIRECT,
    ModeScan   = MODE_SCAN
  } mode_e;

endpackage

// File: rtl/rr_next_ch.sv
// Wrap-around priority search: first enabled channel at or after ptr.
// Ports:
//   ch_en : per-channel enable mask
//   ptr   : search start index
//   found : at least one channel enabled
//   idx   : index of the first enabled channel at or after ptr (wrapping N-1 -> 0)
module rr_next_ch #(
  parameter int unsigned N = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  ch_en,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [SW-1:0] off;

  always_comb begin
    // Rotating the doubled mask right by ptr puts channel ptr at bit 0, so the
    // lowest set bit is the distance from ptr to the target.
    rot   = N'({ch_en, ch_en} >> ptr);
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
    // N is a power of two, so SW-bit addition wraps modulo N.
    idx = ptr + off;
  end

endmodule

// File: rtl/seq_chan_mux.sv
// Registered N-channel, W-bit multiplexer with a valid/ready output stage.
// Direct mode selects channel sel; scan mode round-robins over ch_en.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_data             : N packed channels, channel k at [k*W +: W]
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   mode                : 0 = direct, 1 = scan
//   sel                 : channel index in direct mode
//   ch_en               : channel enable mask in scan mode
//   out_data, out_ch    : held word and the index of its channel
//   out_valid/out_ready : output handshake
module seq_chan_mux
  import seq_mux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   ch_en,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  mode_e         mode_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] search_ptr;
  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic [SW-1:0] target;
  logic [SW-1:0] ptr_next;
  logic          has_target;
  logic          capture;
  logic [W-1:0]  sel_word;

  assign in_ready = !out_valid || out_ready;

  // On the direct -> scan transition the search starts from 0 in that same cycle.
  assign search_ptr = (mode_q == ModeDirect) ? '0 : ptr_q;

  rr_next_ch #(
    .N(N)
  ) u_rr_next_ch (
    .ch_en(ch_en),
    .ptr  (search_ptr),
    .found(rr_found),
    .idx  (rr_idx)
  );

  always_comb begin
    target     = (mode == MODE_SCAN) ? rr_idx : sel;
    has_target = (mode == MODE_DIRECT) || rr_found;
    capture    = in_valid && in_ready && has_target;
    ptr_next   = target + SW'(1);
    sel_word   = in_data[W*int'(target) +: W];
  end

  // Mode FSM and scan pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= ModeDirect;
      ptr_q  <= '0;
    end else begin
      case (mode_q)
        ModeDirect: begin
          if (mode == MODE_SCAN) begin
            mode_q <= ModeScan;
            ptr_q  <= capture ? ptr_next : '0;
          end
        end
        ModeScan: begin
          if (mode == MODE_DIRECT) begin
            mode_q <= ModeDirect;
          end else if (capture) begin
            ptr_q <= ptr_next;
          end
        end
        default: mode_q <= ModeDirect;
      endcase
    end
  end

  // Output register; a capture overwrites the held word even while it is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= sel_word;
      out_ch    <= target;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_chan_mux.sv
module tb_seq_chan_mux;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic           mode;
  logic [2:0]     sel;
  logic [N-1:0]   ch_en;
  logic [W-1:0]   out_data;
  logic [2:0]     out_ch;
  logic           out_valid;
  logic           out_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] ch_en;
    logic       in_valid;
    logic       out_ready;
    logic       exp_valid;
    logic       chk_word;
    logic [2:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  seq_chan_mux #(
    .N(N),
    .W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .ch_en    (ch_en),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [2:0] ch,
                         input logic [7:0] d);
    chk({nm, "_valid"}, 64'(out_valid), 64'(v));
    chk({nm, "_ch"}, 64'(out_ch), 64'(ch));
    chk({nm, "_data"}, 64'(out_data), 64'(d));
  endtask

  task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] en,
                       input logic iv, input logic ordy);
    mode      = m;
    sel       = s;
    ch_en     = en;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

    // Direct sweep, then scan over 1010_0101 starting right after sel=7.
    for (int k = 0; k < 8; k++)
      vecs[k] = '{1'b0, 3'(k), 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'(k), 8'h10 + 8'(k)};
    vecs[8]  = '{1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'h10};
    vecs[9]  = '{1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'h12};
    vecs[10] = '{1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 8'h15};
    vecs[11] = '{1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h17};
    vecs[12] = '{1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'h10};
    vecs[13] = '{1'b1, 3'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'h12};
    vecs[14] = '{1'b1, 3'd0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00};

    #3;
    chk_out("reset", 1'b0, 3'd0, 8'h00);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    #9 rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].ch_en, vecs[i].in_valid, vecs[i].out_ready);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].chk_word) begin
        chk($sformatf("vec%0d_ch", i), 64'(out_ch), 64'(vecs[i].exp_ch));
        chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      end
    end

    // Back-pressure: re-enter scan, hold the first word for 3 cycles.
    drive(1'b0, 3'd0, 8'hA5, 1'b0, 1'b1);
    tick();
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd0, 8'hA5, 1'b1, 1'b0);
    tick();
    chk_out("bp_first", 1'b1, 3'd0, 8'h10);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", k), 1'b1, 3'd0, 8'h10);
      chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp_next", 1'b1, 3'd2, 8'h12);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);

    // Empty enable mask: held word drains, then nothing is captured.
    drive(1'b1, 3'd0, 8'hA5, 1'b1, 1'b1);
    tick();
    chk_out("en0_pre", 1'b1, 3'd5, 8'h15);
    drive(1'b1, 3'd0, 8'h00, 1'b1, 1'b0);
    tick();
    chk_out("en0_hold", 1'b1, 3'd5, 8'h15);
    out_ready = 1'b1;
    #1;
    chk("en0_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("en0_drop0", 64'(out_valid), 64'd0);
    tick();
    chk("en0_drop1", 64'(out_valid), 64'd0);
    ch_en = 8'h08;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("en08_%0d", k), 1'b1, 3'd3, 8'h13);
    end

    // Mode switch restarts the scan from channel 0.
    drive(1'b0, 3'd6, 8'h08, 1'b1, 1'b1);
    tick();
    chk_out("sw_direct", 1'b1, 3'd6, 8'h16);
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
    tick();
    chk_out("sw_scan", 1'b1, 3'd0, 8'h10);
    tick();
    chk_out("sw_scan2", 1'b1, 3'd1, 8'h11);

    // Asynchronous reset pulse between edges.
    #2 rst = 1'b1;
    #1;
    chk_out("arst", 1'b0, 3'd0, 8'h00);
    ch_en = 8'h14;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("arst_after", 1'b1, 3'd2, 8'h12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_chan_mux.md
# seq_chan_mux

Registered, parametrised N-channel, W-bit multiplexer with a valid/ready output stage and two select modes: direct (external select) and auto-scan (round-robin over an enable mask). It is the next generation of the team's fixed 8:1 single-bit mux tree. It serves datapaths that must time-multiplex several sample channels onto one bus without losing words under back-pressure.

## Interface
- N, default 8: channel count; power of two, 2..32.
- W, default 8: data width per channel, 1..64.
- SW, default $clog2(N): select/pointer width (derived, not overridden).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*W  packed channels; channel k at bits [k*W +: W].
- in_valid  in  1  input word set is valid this cycle.
- in_ready  out  1  block can accept a capture this cycle.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- sel  in  SW  channel index used in DIRECT mode.
- ch_en  in  N  per-channel enable mask used in SCAN mode.
- out_data  out  W  registered selected word.
- out_ch  out  SW  index of channel held in out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  downstream accepts the held word.

## Operation
- One clock; reset is asynchronous and active-high.
- Reset values: out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0, mode register=DIRECT.
- in_ready = !out_valid || out_ready (combinational; no bubble under continuous ready).
- Capture (accept) when in_valid && in_ready && a target channel exists.
- DIRECT: target = sel. out_data <= in_data[sel], out_ch <= sel, out_valid <= 1.
- SCAN: target = first enabled channel at or after ptr, searching upward with wrap N-1 -> 0. On capture, ptr <= target+1 (mod N).
- SCAN with ch_en == 0: no target; no capture. in_ready follows the formula, but the accept is dropped. out_valid clears once the held word is consumed.
- No capture while in_ready is high: if out_ready is high, out_valid <= 0.
- out_valid && !out_ready: out_data, out_ch and out_valid hold unchanged. Inputs are ignored.
- Mode FSM, two states DIRECT/SCAN, sampled every cycle:
  - transition DIRECT -> SCAN sets ptr <= 0 in that same cycle;
  - the first scan target is searched from 0;
  - SCAN -> DIRECT leaves ptr unchanged (don't-care).
- ch_en changes take effect the same cycle. ptr is not adjusted.
- sel is unsigned and always in range, because N is a power of two.

## Timing
- Latency: capture at edge t, so out_data is valid after edge t.
- Throughput: one word per cycle while out_ready=1.
- Output is fully registered. The only combinational in->out path is out_ready -> in_ready.
- Reset asserted mid-transfer: outputs go to reset values immediately and the held word is discarded. First capture is possible on the first edge after rst deasserts.
- Simultaneous pop and push (out_valid && out_ready && capture): the new word replaces the old one in the same edge and out_valid stays 1.

## Structure
- Package seq_mux_pkg holds:
  - localparam MODE_DIRECT=1'b0, MODE_SCAN=1'b1;
  - typedef for the mode state.
- Sub-module rr_next_ch (N parameter): inputs ch_en and ptr; outputs found and idx. It is purely combinational: a wrap-around priority search, implemented by a double-width mask rotate.
- Top level contains the data mux (in_data indexed slice), the mode FSM, ptr and the output register.

## Test plan
- DIRECT, N=8, W=8, in_data channel k = 8'h10+k, out_ready=1, sel 0..7 on consecutive cycles -> out_data 10..17 and out_ch 0..7, one per cycle, no bubbles.
- SCAN, ch_en=8'b1010_0101, out_ready=1, in_valid held 1 -> out_ch sequence 0,2,5,7,0,2…; out_data matches each channel.
- Back-pressure: SCAN with out_ready=0 for 3 cycles after the first capture -> out_ch=0 held, in_ready=0. Release -> next out_ch=2, with no channel skipped.
- ch_en=0 in SCAN with in_valid=1 -> out_valid drops after the current word is consumed and stays 0. Then set ch_en=8'h08 -> out_ch=3 repeatedly.
- Mode switch: DIRECT sel=6, then mode=1 with ch_en=8'hFF -> first scan out_ch=0 (ptr reset), not 7.
- Async reset pulse mid-stream (between clock edges) -> out_valid=0, out_data=0 and out_ch=0 immediately. After release in SCAN, first out_ch is the first enabled channel ≥0.
